// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I opcodes, ROB tag type, shadow entry and retirement packet layouts
package rv32i_types;
  localparam int ROB_TAG_W = 3;
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  localparam logic [6:0] op_lui   = 7'b0110111;
  localparam logic [6:0] op_auipc = 7'b0010111;
  localparam logic [6:0] op_jal   = 7'b1101111;
  localparam logic [6:0] op_jalr  = 7'b1100111;
  localparam logic [6:0] op_br    = 7'b1100011;
  localparam logic [6:0] op_load  = 7'b0000011;
  localparam logic [6:0] op_store = 7'b0100011;
  localparam logic [6:0] op_imm   = 7'b0010011;
  localparam logic [6:0] op_reg   = 7'b0110011;
  typedef struct packed {
    logic        valid;
    logic        done;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] rd_wdata;
  } rvfi_entry_t;
  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd_wdata;
    logic        load_rf;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
  } rvfi_pkt_t;
endpackage

// File: rtl/rvfi_field_decode.sv
// rvfi_field_decode: RV32I instruction word to rs1/rs2/rd indices (unused fields zeroed) and control-flow flag
module rvfi_field_decode
  import rv32i_types::*;
(
  input  logic [31:0] inst,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        is_ctrl
);
  logic [6:0] op;
  assign op = inst[6:0];
  always_comb begin
    rs1     = (op == op_lui || op == op_auipc || op == op_jal) ? 5'd0 : inst[19:15];
    rs2     = (op == op_reg || op == op_store || op == op_br) ? inst[24:20] : 5'd0;
    rd      = (op == op_store || op == op_br) ? 5'd0 : inst[11:7];
    is_ctrl = op == op_br || op == op_jal || op == op_jalr;
  end
endmodule

// File: rtl/rvfi_commit_tracker.sv
// rvfi_commit_tracker: per-ROB-tag shadow buffer that assembles one registered RVFI packet per commit
module rvfi_commit_tracker
  import rv32i_types::*;
#(
  parameter int ROB_DEPTH = 8,
  parameter int TAG_W     = $clog2(ROB_DEPTH),
  parameter int NUM_CDB   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     disp_valid,
  input  logic [TAG_W-1:0]         disp_tag,
  input  logic [31:0]              disp_inst,
  input  logic [31:0]              disp_pc,
  input  logic [31:0]              disp_pc_next,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*32-1:0]    cdb_data,
  input  logic [NUM_CDB-1:0]       cdb_redirect,
  input  logic [NUM_CDB*32-1:0]    cdb_target,
  input  logic                     commit_valid,
  input  logic [TAG_W-1:0]         commit_tag,
  input  logic                     flush,
  output logic                     rvfi_valid,
  output logic [63:0]              rvfi_order,
  output logic [31:0]              rvfi_inst,
  output logic [4:0]               rvfi_rs1_addr,
  output logic [4:0]               rvfi_rs2_addr,
  output logic [4:0]               rvfi_rd_addr,
  output logic [31:0]              rvfi_rd_wdata,
  output logic                     rvfi_load_rf,
  output logic [31:0]              rvfi_pc_rdata,
  output logic [31:0]              rvfi_pc_wdata,
  output logic                     err
);
  rvfi_entry_t ent_q [ROB_DEPTH];
  rvfi_entry_t ent_d [ROB_DEPTH];
  rvfi_entry_t cm;
  rvfi_pkt_t pkt_q, pkt_d;
  logic valid_q, err_q, err_d;
  logic [63:0] order_q, order_d;
  logic [ROB_DEPTH-1:0] seen;
  logic [TAG_W-1:0] ctag [NUM_CDB];
  logic [4:0] d_rs1, d_rs2, d_rd, c_rs1, c_rs2, c_rd;
  logic d_ctrl, c_ctrl, unused_dec;
  rvfi_field_decode u_disp_dec (
    .inst(disp_inst), .rs1(d_rs1), .rs2(d_rs2), .rd(d_rd), .is_ctrl(d_ctrl)
  );
  rvfi_field_decode u_cmt_dec (
    .inst(ent_q[commit_tag].inst), .rs1(c_rs1), .rs2(c_rs2), .rd(c_rd), .is_ctrl(c_ctrl)
  );
  assign unused_dec = ^{d_rs1, d_rs2, c_ctrl};
  always_comb begin
    for (int p = 0; p < NUM_CDB; p++) ctag[p] = cdb_tag[p*TAG_W +: TAG_W];
  end
  always_comb begin
    ent_d   = ent_q;
    err_d   = err_q;
    seen    = '0;
    pkt_d   = '0;
    order_d = valid_q ? order_q + 64'd1 : order_q;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (cdb_valid[p]) begin
        if (!ent_q[ctag[p]].valid || seen[ctag[p]]) err_d = 1'b1;
        else begin
          seen[ctag[p]]           = 1'b1;
          ent_d[ctag[p]].done     = 1'b1;
          ent_d[ctag[p]].rd_wdata = cdb_data[p*32 +: 32];
          if (cdb_redirect[p]) ent_d[ctag[p]].pc_next = cdb_target[p*32 +: 32];
        end
      end
    end
    // reading after the CDB pass gives the same-cycle bypass for free
    cm = ent_d[commit_tag];
    if (commit_valid) begin
      err_d = err_d | !cm.valid | !cm.done;
      pkt_d = '{inst: cm.inst, rs1: c_rs1, rs2: c_rs2, rd: c_rd,
                rd_wdata: (c_rd == 5'd0) ? 32'd0 : cm.rd_wdata, load_rf: c_rd != 5'd0,
                pc_rdata: cm.pc, pc_wdata: cm.pc_next};
      ent_d[commit_tag].valid = 1'b0;
    end
    if (flush) for (int i = 0; i < ROB_DEPTH; i++) ent_d[i].valid = 1'b0;
    if (disp_valid && !flush) begin
      err_d = err_d | (ent_q[disp_tag].valid && !(commit_valid && commit_tag == disp_tag));
      ent_d[disp_tag] = '{valid: 1'b1, done: !d_ctrl && d_rd == 5'd0, inst: disp_inst,
                          pc: disp_pc, pc_next: disp_pc_next, rd_wdata: 32'd0};
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q   <= '{default: '0};
      pkt_q   <= '0;
      valid_q <= 1'b0;
      order_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      pkt_q   <= pkt_d;
      valid_q <= commit_valid;
      order_q <= order_d;
      err_q   <= err_d;
    end
  end
  assign rvfi_valid    = valid_q;
  assign rvfi_order    = order_q;
  assign rvfi_inst     = pkt_q.inst;
  assign rvfi_rs1_addr = pkt_q.rs1;
  assign rvfi_rs2_addr = pkt_q.rs2;
  assign rvfi_rd_addr  = pkt_q.rd;
  assign rvfi_rd_wdata = pkt_q.rd_wdata;
  assign rvfi_load_rf  = pkt_q.load_rf;
  assign rvfi_pc_rdata = pkt_q.pc_rdata;
  assign rvfi_pc_wdata = pkt_q.pc_wdata;
  assign err           = err_q;
endmodule
